// File: rtl/rs_age_ordered_station.sv
// rs_age_ordered_station: reservation station for integer ALU ops with
// oldest-ready-first issue (age matrix), CDB wakeup/forwarding and
// speculative flush/commit.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   i_iq_*                            dispatch from instruction queue (valid/ready)
//   i_branch_valid / _correct_pred.   branch resolution: commit (1) or flush (0)
//   i_cdb_valid/_tag/_data            NUM_CDB broadcast ports
//   o_exe_*                           issue to execution (valid/ready), combinational
// Optional (macro RS_OCCUPANCY_EN): o_occupancy, registered count of valid entries.
module rs_age_ordered_station #(
  parameter int unsigned BW_DATA     = 32,
  parameter int unsigned BW_OPCODE   = 3,
  parameter int unsigned BW_TAG      = 4,
  parameter int unsigned NUM_ENTRY   = 8,
  parameter int unsigned NUM_OPERAND = 2,
  parameter int unsigned NUM_CDB     = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_iq_valid,
  output logic                           i_iq_ready,
  input  logic [BW_OPCODE-1:0]           i_iq_opcode,
  input  logic [NUM_OPERAND*BW_TAG-1:0]  i_iq_Q_flatten,
  input  logic [NUM_OPERAND*BW_DATA-1:0] i_iq_V_flatten,
  input  logic [BW_TAG-1:0]              i_iq_tag,
  input  logic                           i_iq_speculation,
  input  logic                           i_branch_valid,
  input  logic                           i_branch_correct_prediction,
  input  logic [NUM_CDB-1:0]             i_cdb_valid,
  input  logic [NUM_CDB*BW_TAG-1:0]      i_cdb_tag,
  input  logic [NUM_CDB*BW_DATA-1:0]     i_cdb_data,
  output logic                           o_exe_valid,
  input  logic                           o_exe_ready,
  output logic [BW_OPCODE-1:0]           o_exe_opcode,
  output logic [BW_TAG-1:0]              o_exe_tag,
  output logic [NUM_OPERAND*BW_DATA-1:0] o_exe_V_flatten
`ifdef RS_OCCUPANCY_EN
  ,
  output logic [$clog2(NUM_ENTRY+1)-1:0] o_occupancy
`endif
);

  localparam int unsigned IDX_W = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;

  // Entry storage; older_r[i][j] = 1 means entry j is older than entry i.
  logic [NUM_ENTRY-1:0] valid_r, spec_r, valid_n, spec_n;
  logic [BW_OPCODE-1:0] op_r    [NUM_ENTRY];
  logic [BW_OPCODE-1:0] op_n    [NUM_ENTRY];
  logic [BW_TAG-1:0]    tag_r   [NUM_ENTRY];
  logic [BW_TAG-1:0]    tag_n   [NUM_ENTRY];
  logic [BW_TAG-1:0]    q_r     [NUM_ENTRY][NUM_OPERAND];
  logic [BW_TAG-1:0]    q_n     [NUM_ENTRY][NUM_OPERAND];
  logic [BW_DATA-1:0]   v_r     [NUM_ENTRY][NUM_OPERAND];
  logic [BW_DATA-1:0]   v_n     [NUM_ENTRY][NUM_OPERAND];
  logic [NUM_ENTRY-1:0] older_r [NUM_ENTRY];
  logic [NUM_ENTRY-1:0] older_n [NUM_ENTRY];

  logic [NUM_ENTRY-1:0] ready_c;
  logic [IDX_W-1:0]     sel_idx, alloc_idx;
  logic                 any_ready, flush, issue_fire, disp_fire;
  logic [BW_DATA:0]     lk;
  logic [BW_TAG-1:0]    qin;

  // First matching CDB port wins; returns {hit, data}.
  function automatic logic [BW_DATA:0] cdb_lookup(
    input logic [BW_TAG-1:0]          q,
    input logic [NUM_CDB-1:0]         cv,
    input logic [NUM_CDB*BW_TAG-1:0]  ct,
    input logic [NUM_CDB*BW_DATA-1:0] cd
  );
    logic [BW_DATA:0] r;
    r = '0;
    for (int p = 0; p < NUM_CDB; p++) begin
      if (!r[BW_DATA] && cv[p] && (ct[p*BW_TAG +: BW_TAG] == q))
        r = {1'b1, cd[p*BW_DATA +: BW_DATA]};
    end
    return r;
  endfunction

  // Readiness, oldest-ready selection and lowest free slot.
  always_comb begin
    ready_c   = '0;
    sel_idx   = '0;
    alloc_idx = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      ready_c[i] = valid_r[i];
      for (int k = 0; k < NUM_OPERAND; k++)
        if (q_r[i][k] != '0) ready_c[i] = 1'b0;
    end
    for (int i = 0; i < NUM_ENTRY; i++)
      if (ready_c[i] && ((older_r[i] & ready_c) == '0)) sel_idx = IDX_W'(i);
    for (int i = NUM_ENTRY - 1; i >= 0; i--)
      if (!valid_r[i]) alloc_idx = IDX_W'(i);
  end

  assign any_ready  = |ready_c;
  assign flush      = i_branch_valid && !i_branch_correct_prediction;
  assign i_iq_ready = ~&valid_r;
  assign disp_fire  = i_iq_valid && i_iq_ready;
  // A speculative winner is masked during a flush so it never hands off.
  assign o_exe_valid = any_ready && !(flush && spec_r[sel_idx]);
  assign issue_fire  = o_exe_valid && o_exe_ready;

  // Issue payload from the selected entry.
  always_comb begin
    o_exe_opcode    = '0;
    o_exe_tag       = '0;
    o_exe_V_flatten = '0;
    if (any_ready) begin
      o_exe_opcode = op_r[sel_idx];
      o_exe_tag    = tag_r[sel_idx];
      for (int k = 0; k < NUM_OPERAND; k++)
        o_exe_V_flatten[k*BW_DATA +: BW_DATA] = v_r[sel_idx][k];
    end
  end

  // Next state: wakeup, issue, branch resolution, then dispatch.
  always_comb begin
    valid_n = valid_r;
    spec_n  = spec_r;
    op_n    = op_r;
    tag_n   = tag_r;
    q_n     = q_r;
    v_n     = v_r;
    older_n = older_r;
    lk      = '0;
    qin     = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      for (int k = 0; k < NUM_OPERAND; k++) begin
        if (valid_r[i] && (q_r[i][k] != '0)) begin
          lk = cdb_lookup(q_r[i][k], i_cdb_valid, i_cdb_tag, i_cdb_data);
          if (lk[BW_DATA]) begin
            q_n[i][k] = '0;
            v_n[i][k] = lk[BW_DATA-1:0];
          end
        end
      end
    end
    if (issue_fire) valid_n[sel_idx] = 1'b0;
    if (flush) valid_n = valid_n & ~spec_r;
    if (i_branch_valid) spec_n = '0;
    if (disp_fire) begin
      // Reused slot: forget stale ordering, then sit behind every survivor.
      for (int i = 0; i < NUM_ENTRY; i++) older_n[i][alloc_idx] = 1'b0;
      older_n[alloc_idx] = valid_n;
      valid_n[alloc_idx] = !(flush && i_iq_speculation);
      spec_n[alloc_idx]  = i_iq_speculation && !i_branch_valid;
      op_n[alloc_idx]    = i_iq_opcode;
      tag_n[alloc_idx]   = i_iq_tag;
      for (int k = 0; k < NUM_OPERAND; k++) begin
        qin = i_iq_Q_flatten[k*BW_TAG +: BW_TAG];
        q_n[alloc_idx][k] = qin;
        v_n[alloc_idx][k] = i_iq_V_flatten[k*BW_DATA +: BW_DATA];
        if (qin != '0) begin
          lk = cdb_lookup(qin, i_cdb_valid, i_cdb_tag, i_cdb_data);
          if (lk[BW_DATA]) begin
            q_n[alloc_idx][k] = '0;
            v_n[alloc_idx][k] = lk[BW_DATA-1:0];
          end
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      spec_r  <= '0;
      for (int i = 0; i < NUM_ENTRY; i++) begin
        op_r[i]    <= '0;
        tag_r[i]   <= '0;
        older_r[i] <= '0;
        for (int k = 0; k < NUM_OPERAND; k++) begin
          q_r[i][k] <= '0;
          v_r[i][k] <= '0;
        end
      end
    end else begin
      valid_r <= valid_n;
      spec_r  <= spec_n;
      op_r    <= op_n;
      tag_r   <= tag_n;
      q_r     <= q_n;
      v_r     <= v_n;
      older_r <= older_n;
    end
  end

`ifdef RS_OCCUPANCY_EN
  localparam int unsigned OCC_W = $clog2(NUM_ENTRY + 1);
  logic [OCC_W-1:0] occ_n;

  // Population count of next-cycle valid entries.
  always_comb begin
    occ_n = '0;
    for (int i = 0; i < NUM_ENTRY; i++) occ_n = occ_n + OCC_W'(valid_n[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_occupancy <= '0;
    else        o_occupancy <= occ_n;
  end
`endif

endmodule

// File: tb/tb_rs_age_ordered_station.sv
// Directed bench for rs_age_ordered_station with an issue-order scoreboard.
module tb_rs_age_ordered_station;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_iq_valid, i_iq_ready;
  logic [2:0]  i_iq_opcode;
  logic [7:0]  i_iq_Q_flatten;
  logic [63:0] i_iq_V_flatten;
  logic [3:0]  i_iq_tag;
  logic        i_iq_speculation;
  logic        i_branch_valid, i_branch_correct_prediction;
  logic [1:0]  i_cdb_valid;
  logic [7:0]  i_cdb_tag;
  logic [63:0] i_cdb_data;
  logic        o_exe_valid, o_exe_ready;
  logic [2:0]  o_exe_opcode;
  logic [3:0]  o_exe_tag;
  logic [63:0] o_exe_V_flatten;
`ifdef RS_OCCUPANCY_EN
  logic [3:0]  o_occupancy;
`endif

  rs_age_ordered_station dut (
    .clk(clk), .rst_n(rst_n),
    .i_iq_valid(i_iq_valid), .i_iq_ready(i_iq_ready),
    .i_iq_opcode(i_iq_opcode), .i_iq_Q_flatten(i_iq_Q_flatten),
    .i_iq_V_flatten(i_iq_V_flatten), .i_iq_tag(i_iq_tag),
    .i_iq_speculation(i_iq_speculation),
    .i_branch_valid(i_branch_valid),
    .i_branch_correct_prediction(i_branch_correct_prediction),
    .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data),
    .o_exe_valid(o_exe_valid), .o_exe_ready(o_exe_ready),
    .o_exe_opcode(o_exe_opcode), .o_exe_tag(o_exe_tag),
    .o_exe_V_flatten(o_exe_V_flatten)
`ifdef RS_OCCUPANCY_EN
    , .o_occupancy(o_occupancy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  tag;
    logic [63:0] v;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic expect_issue(input logic [2:0] op, input logic [3:0] tag,
                              input logic [31:0] v0, input logic [31:0] v1);
    sb.push_back('{op: op, tag: tag, v: {v1, v0}});
  endtask

  task automatic dispatch(input logic [2:0] op, input logic [3:0] tag, input logic [3:0] q0,
                          input logic [31:0] v0, input logic [31:0] v1, input logic spec);
    i_iq_valid       = 1'b1;
    i_iq_opcode      = op;
    i_iq_tag         = tag;
    i_iq_Q_flatten   = {4'd0, q0};
    i_iq_V_flatten   = {v1, v0};
    i_iq_speculation = spec;
    tick();
    i_iq_valid       = 1'b0;
    i_iq_speculation = 1'b0;
  endtask

  // Accept n issues, checking each against the scoreboard head.
  task automatic drain(input int n);
    int got = 0;
    int cyc = 0;
    exp_t e;
    o_exe_ready = 1'b1;
    while (got < n && cyc < 64) begin
      #1;
      if (o_exe_valid) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          chk("issue_optag", {57'd0, o_exe_opcode, o_exe_tag}, {57'd0, e.op, e.tag});
          chk("issue_v", o_exe_V_flatten, e.v);
        end
        got++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    o_exe_ready = 1'b0;
    if (got < n) chk("drain_timeout", 64'(got), 64'(n));
  endtask

  task automatic cdb_set(input logic [1:0] v, input logic [3:0] t0, input logic [31:0] d0,
                         input logic [3:0] t1, input logic [31:0] d1);
    i_cdb_valid = v;
    i_cdb_tag   = {t1, t0};
    i_cdb_data  = {d1, d0};
  endtask

  initial begin
    rst_n = 1'b0;
    i_iq_valid = 1'b0; i_iq_opcode = '0; i_iq_Q_flatten = '0; i_iq_V_flatten = '0;
    i_iq_tag = '0; i_iq_speculation = 1'b0;
    i_branch_valid = 1'b0; i_branch_correct_prediction = 1'b0;
    i_cdb_valid = '0; i_cdb_tag = '0; i_cdb_data = '0;
    o_exe_ready = 1'b0;
    #1;
    chk("rst_exe_valid", 64'(o_exe_valid), 64'd0);
    chk("rst_iq_ready", 64'(i_iq_ready), 64'd1);
    chk("rst_exe_v", o_exe_V_flatten, 64'd0);
    chk("rst_exe_op", 64'(o_exe_opcode), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic dispatch -> issue.
    dispatch(3'd3, 4'd5, 4'd0, 32'd10, 32'd20, 1'b0);
    chk("basic_valid", 64'(o_exe_valid), 64'd1);
    expect_issue(3'd3, 4'd5, 32'd10, 32'd20);
    drain(1);
    chk("basic_freed", 64'(o_exe_valid), 64'd0);

    // Waiting entry bypassed by younger ready one; wakeup on CDB port 1.
    dispatch(3'd1, 4'd1, 4'd7, 32'd0, 32'd2, 1'b0);
    dispatch(3'd2, 4'd2, 4'd0, 32'd3, 32'd4, 1'b0);
    expect_issue(3'd2, 4'd2, 32'd3, 32'd4);
    drain(1);
    cdb_set(2'b10, 4'd0, 32'd0, 4'd7, 32'd99);
    #1;
    chk("no_same_cycle_wake", 64'(o_exe_valid), 64'd0);
    tick();
    cdb_set(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    expect_issue(3'd1, 4'd1, 32'd99, 32'd2);
    drain(1);

    // Dispatch-time forwarding, port 0 wins over port 1 on same tag.
    cdb_set(2'b11, 4'd7, 32'd99, 4'd7, 32'd55);
    dispatch(3'd4, 4'd6, 4'd7, 32'd0, 32'd8, 1'b0);
    cdb_set(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    chk("fwd_ready", 64'(o_exe_valid), 64'd1);
    expect_issue(3'd4, 4'd6, 32'd99, 32'd8);
    drain(1);

    // Fill all 8 entries waiting on tag 9, then release in age order.
    for (int i = 0; i < 8; i++)
      dispatch(3'(i), 4'(i + 1), 4'd9, 32'd0, 32'(i + 100), 1'b0);
    chk("full_iq_ready", 64'(i_iq_ready), 64'd0);
    dispatch(3'd7, 4'd15, 4'd0, 32'd1, 32'd1, 1'b0);
    chk("full_no_issue", 64'(o_exe_valid), 64'd0);
`ifdef RS_OCCUPANCY_EN
    chk("full_occ", 64'(o_occupancy), 64'd8);
`endif
    cdb_set(2'b01, 4'd9, 32'h900, 4'd0, 32'd0);
    tick();
    cdb_set(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    for (int i = 0; i < 8; i++) expect_issue(3'(i), 4'(i + 1), 32'h900, 32'(i + 100));
    drain(8);
    chk("full_drained", 64'(o_exe_valid), 64'd0);
    chk("full_ready_back", 64'(i_iq_ready), 64'd1);

    // Flush: two spec + one non-spec, plus a same-cycle spec dispatch.
    dispatch(3'd1, 4'd1, 4'd0, 32'd11, 32'd12, 1'b1);
    dispatch(3'd2, 4'd2, 4'd0, 32'd21, 32'd22, 1'b1);
    dispatch(3'd3, 4'd3, 4'd0, 32'd31, 32'd32, 1'b0);
    i_branch_valid = 1'b1; i_branch_correct_prediction = 1'b0;
    i_iq_valid = 1'b1; i_iq_speculation = 1'b1; i_iq_opcode = 3'd5; i_iq_tag = 4'd9;
    i_iq_Q_flatten = '0; i_iq_V_flatten = 64'd5;
    o_exe_ready = 1'b1;
    #1;
    chk("flush_masked", 64'(o_exe_valid), 64'd0);
    tick();
    i_branch_valid = 1'b0; i_iq_valid = 1'b0; i_iq_speculation = 1'b0; o_exe_ready = 1'b0;
`ifdef RS_OCCUPANCY_EN
    chk("flush_occ", 64'(o_occupancy), 64'd1);
`endif
    expect_issue(3'd3, 4'd3, 32'd31, 32'd32);
    drain(1);
    chk("flush_empty", 64'(o_exe_valid), 64'd0);

    // Commit: spec bits cleared incl. same-cycle dispatch; later flush is harmless.
    dispatch(3'd1, 4'd1, 4'd0, 32'd11, 32'd12, 1'b1);
    dispatch(3'd2, 4'd2, 4'd0, 32'd21, 32'd22, 1'b1);
    dispatch(3'd3, 4'd3, 4'd0, 32'd31, 32'd32, 1'b0);
    i_branch_valid = 1'b1; i_branch_correct_prediction = 1'b1;
    dispatch(3'd4, 4'd4, 4'd0, 32'd41, 32'd42, 1'b1);
    i_branch_correct_prediction = 1'b0;
    #1;
    chk("commit_then_flush_valid", 64'(o_exe_valid), 64'd1);
    chk("commit_then_flush_op", 64'(o_exe_opcode), 64'd1);
    tick();
    i_branch_valid = 1'b0;
`ifdef RS_OCCUPANCY_EN
    chk("commit_occ", 64'(o_occupancy), 64'd4);
`endif
    for (int i = 1; i <= 4; i++)
      expect_issue(3'(i), 4'(i), 32'(i * 10 + 1), 32'(i * 10 + 2));
    drain(4);
    chk("commit_empty", 64'(o_exe_valid), 64'd0);

    // Back-pressure: outputs hold steady while ready is low.
    dispatch(3'd6, 4'd3, 4'd0, 32'hAA, 32'hBB, 1'b0);
    for (int c = 0; c < 5; c++) begin
      chk("hold_valid", 64'(o_exe_valid), 64'd1);
      chk("hold_payload", o_exe_V_flatten, {32'hBB, 32'hAA});
      tick();
    end
    expect_issue(3'd6, 4'd3, 32'hAA, 32'hBB);
    drain(1);
    chk("hold_single", 64'(o_exe_valid), 64'd0);

    // Reset mid-stream drops everything.
    for (int i = 0; i < 4; i++) dispatch(3'(i), 4'(i + 1), 4'd0, 32'(i), 32'(i), 1'b0);
    chk("pre_rst_valid", 64'(o_exe_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_exe_valid", 64'(o_exe_valid), 64'd0);
    chk("mid_rst_iq_ready", 64'(i_iq_ready), 64'd1);
    tick(); tick();
    rst_n = 1'b1;
    o_exe_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_rst_idle", 64'(o_exe_valid), 64'd0);
    end
    o_exe_ready = 1'b0;
    chk("sb_leftover", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
